// File: rtl/work_dispatcher.sv
// Job sequencer: splits a nonce range across NUM_CORES cores, tracks completion and
// merges per-core result pulses into one FIFO stream. Optional result_count port under WORK_DISPATCHER_STATS_EN.
module work_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int LOG2_CORES = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     work_valid,
    input  logic [31:0]              work_nonce_start,
    input  logic [31:0]              work_nonce_end,
    output logic [NUM_CORES-1:0]     core_new_work,
    output logic [32*NUM_CORES-1:0]  core_nonce_start,
    output logic [32*NUM_CORES-1:0]  core_nonce_end,
    input  logic [NUM_CORES-1:0]     core_hashing,
    input  logic [NUM_CORES-1:0]     core_new_result,
    input  logic [32*NUM_CORES-1:0]  core_result_data,
    output logic                     busy,
    output logic                     done,
    output logic                     result_valid,
    output logic [31:0]              result_nonce,
    input  logic                     result_ready,
    output logic                     overflow
`ifdef WORK_DISPATCHER_STATS_EN
    ,
    output logic [31:0]              result_count
`endif
);

    // state    | meaning
    // S_IDLE   | no job; waiting for work_valid
    // S_LAUNCH | core_new_work pulsed to active cores
    // S_ARM    | one cycle for core_hashing to rise
    // S_RUN    | waiting for all active cores to drop core_hashing
    // S_FINISH | done pulse, then back to idle
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_FINISH} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (LOG2_CORES > 0) ? LOG2_CORES : 1;

    state_t                    r_state, w_state_nxt;
    logic [NUM_CORES-1:0]      r_mask;
    logic [NUM_CORES-1:0]      r_pending;
    logic [31:0]               r_held [NUM_CORES];
    logic [RW-1:0]             r_rr;
    logic                      r_rej_done;
    logic                      r_overflow;
    logic [31:0]               r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]             r_count;

    logic [32:0]               w_n, w_slice;
    logic [31:0]               w_base;
    logic                      w_reject, w_launch, w_flush;
    logic [NUM_CORES-1:0]      w_mask_nxt;
    logic [32*NUM_CORES-1:0]   w_start_nxt, w_end_nxt;
    logic [NUM_CORES-1:0]      w_cap;
    logic                      w_grant_vld;
    logic [RW-1:0]             w_grant_idx;
    int                        w_idx;
    logic                      w_push, w_pop, w_can_push;
    logic [NUM_CORES-1:0]      w_pending_nxt;

    // Slice computation; 33-bit count so a full 2^32 range is representable.
    always_comb begin
        w_n         = {1'b0, work_nonce_end} - {1'b0, work_nonce_start} + 33'd1;
        w_slice     = w_n >> LOG2_CORES;
        w_reject    = work_nonce_end < work_nonce_start;
        w_mask_nxt  = '0;
        w_start_nxt = '0;
        w_end_nxt   = '0;
        w_base      = '0;
        if (w_slice == 33'd0) begin
            w_mask_nxt[0]     = 1'b1;
            w_start_nxt[31:0] = work_nonce_start;
            w_end_nxt[31:0]   = work_nonce_end;
        end else begin
            w_mask_nxt = '1;
            for (int i = 0; i < NUM_CORES; i++) begin
                w_base = work_nonce_start + 32'(33'(i) * w_slice);
                w_start_nxt[32*i +: 32] = w_base;
                w_end_nxt[32*i +: 32]   = (i == NUM_CORES - 1) ? work_nonce_end
                                                               : w_base + w_slice[31:0] - 32'd1;
            end
        end
    end

    assign w_launch = work_valid && !w_reject;
    assign w_flush  = work_valid && (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_launch) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_ARM;
            S_ARM:    w_state_nxt = S_RUN;
            S_RUN:    if ((core_hashing & r_mask) == '0) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = w_reject ? S_IDLE : S_LAUNCH;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    assign core_new_work = (r_state == S_LAUNCH) ? r_mask : '0;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FINISH) || r_rej_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask           <= '0;
            core_nonce_start <= '0;
            core_nonce_end   <= '0;
            r_rej_done       <= 1'b0;
        end else begin
            r_rej_done <= work_valid && w_reject;
            if (w_launch) begin
                r_mask           <= w_mask_nxt;
                core_nonce_start <= w_start_nxt;
                core_nonce_end   <= w_end_nxt;
            end
        end
    end

    // Results are ignored while a job is being (re)launched.
    assign w_cap = (w_flush || r_state == S_LAUNCH) ? '0 : core_new_result;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = (int'(r_rr) + k) % NUM_CORES;
            if (!w_grant_vld && r_pending[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = RW'(w_idx);
            end
        end
    end

    assign result_valid = (r_count != '0);
    assign result_nonce = result_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop        = result_valid && result_ready;
    assign w_can_push   = (r_count != CW'(FIFO_DEPTH)) || w_pop;
    assign w_push       = w_grant_vld && w_can_push && !w_flush;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_push) w_pending_nxt[w_grant_idx] = 1'b0;
        w_pending_nxt = w_pending_nxt | (w_cap & ~r_pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_rr       <= '0;
        end else if (w_flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if ((w_cap & r_pending) != '0) r_overflow <= 1'b1;
            if (w_push) begin
                if (w_grant_idx == RW'(NUM_CORES - 1)) r_rr <= '0;
                else                                   r_rr <= w_grant_idx + RW'(1);
            end
        end
    end

    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (w_cap[i] && !r_pending[i]) r_held[i] <= core_result_data[32*i +: 32];
        if (w_push) r_mem[r_wr_ptr] <= r_held[w_grant_idx];
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WORK_DISPATCHER_STATS_EN
    logic [31:0] r_result_count;
    always_ff @(posedge clk) begin
        if (reset)                                  r_result_count <= '0;
        else if (w_push && r_result_count != '1)    r_result_count <= r_result_count + 32'd1;
    end
    assign result_count = r_result_count;
`endif

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed self-checking bench for work_dispatcher (NUM_CORES=4, FIFO_DEPTH=8).
module tb_work_dispatcher;

    logic         clk;
    logic         reset;
    logic         work_valid;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic [3:0]   core_new_work;
    logic [127:0] core_nonce_start;
    logic [127:0] core_nonce_end;
    logic [3:0]   core_hashing;
    logic [3:0]   core_new_result;
    logic [127:0] core_result_data;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic [31:0]  result_nonce;
    logic         result_ready;
    logic         overflow;
`ifdef WORK_DISPATCHER_STATS_EN
    logic [31:0]  result_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    work_dispatcher #(.NUM_CORES(4), .LOG2_CORES(2), .FIFO_DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .work_valid       (work_valid),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
        .core_new_work    (core_new_work),
        .core_nonce_start (core_nonce_start),
        .core_nonce_end   (core_nonce_end),
        .core_hashing     (core_hashing),
        .core_new_result  (core_new_result),
        .core_result_data (core_result_data),
        .busy             (busy),
        .done             (done),
        .result_valid     (result_valid),
        .result_nonce     (result_nonce),
        .result_ready     (result_ready),
        .overflow         (overflow)
`ifdef WORK_DISPATCHER_STATS_EN
        ,
        .result_count     (result_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e);
        work_valid = 1'b1; work_nonce_start = s; work_nonce_end = e;
        tick();
        work_valid = 1'b0;
        tick();
        core_hashing = 4'hF;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; work_valid = 1'b0; work_nonce_start = '0; work_nonce_end = '0;
        core_hashing = '0; core_new_result = '0; core_result_data = '0; result_ready = 1'b0;
        tick(); tick();
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        vec_cnt++; if (result_nonce !== 32'h0) begin err_cnt++; $display("FAIL reset_nonce: got %h expected 0", result_nonce); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        vec_cnt++; if (core_new_work !== 4'h0) begin err_cnt++; $display("FAIL reset_new_work: got %h expected 0", core_new_work); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_split();
        work_valid = 1'b1; work_nonce_start = 32'd0; work_nonce_end = 32'd99;
        tick();
        work_valid = 1'b0;
        vec_cnt++; if (core_new_work !== 4'hF) begin err_cnt++; $display("FAIL split_new_work: got %h expected f", core_new_work); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL split_busy: got %b expected 1", busy); end
        vec_cnt++; if (core_nonce_start !== {32'd75, 32'd50, 32'd25, 32'd0})
            begin err_cnt++; $display("FAIL split_start: got %h expected %h", core_nonce_start, {32'd75, 32'd50, 32'd25, 32'd0}); end
        vec_cnt++; if (core_nonce_end !== {32'd99, 32'd74, 32'd49, 32'd24})
            begin err_cnt++; $display("FAIL split_end: got %h expected %h", core_nonce_end, {32'd99, 32'd74, 32'd49, 32'd24}); end
        tick();
        vec_cnt++; if (core_new_work !== 4'h0) begin err_cnt++; $display("FAIL split_one_pulse: got %h expected 0", core_new_work); end
        core_hashing = 4'hF;
        tick();
        vec_cnt++; if (busy !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL split_run: busy %b done %b expected 1 0", busy, done); end
    endtask

    task automatic test_round_robin();
        result_ready = 1'b1;
        core_result_data = {32'h73, 32'h0, 32'h31, 32'h0};
        core_new_result = 4'b1010;
        tick();
        core_new_result = 4'b0000;
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_latency: got valid %b expected 0", result_valid); end
        tick();
        vec_cnt++; if (result_valid !== 1'b1 || result_nonce !== 32'h31)
            begin err_cnt++; $display("FAIL rr_first: got %b/%h expected 1/00000031", result_valid, result_nonce); end
        tick();
        vec_cnt++; if (result_valid !== 1'b1 || result_nonce !== 32'h73)
            begin err_cnt++; $display("FAIL rr_second: got %b/%h expected 1/00000073", result_valid, result_nonce); end
        tick();
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_drain: got valid %b expected 0", result_valid); end
        // rr should be back at 0, so core 0 wins over core 3
        core_result_data = {32'hA3, 32'h0, 32'h0, 32'hA0};
        core_new_result = 4'b1001;
        tick();
        core_new_result = 4'b0000;
        tick();
        vec_cnt++; if (result_nonce !== 32'hA0) begin err_cnt++; $display("FAIL rr_wrap_first: got %h expected 000000a0", result_nonce); end
        tick();
        vec_cnt++; if (result_nonce !== 32'hA3) begin err_cnt++; $display("FAIL rr_wrap_second: got %h expected 000000a3", result_nonce); end
        tick();
        core_hashing = 4'h0;
        tick();
        vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL rr_done: got %b expected 1", done); end
        tick();
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rr_idle: done %b busy %b expected 0 0", done, busy); end
    endtask

    task automatic test_small_range();
        work_valid = 1'b1; work_nonce_start = 32'd10; work_nonce_end = 32'd12;
        tick();
        work_valid = 1'b0;
        vec_cnt++; if (core_new_work !== 4'h1) begin err_cnt++; $display("FAIL small_new_work: got %h expected 1", core_new_work); end
        vec_cnt++; if (core_nonce_start[31:0] !== 32'd10 || core_nonce_end[31:0] !== 32'd12)
            begin err_cnt++; $display("FAIL small_range: got %0d..%0d expected 10..12", core_nonce_start[31:0], core_nonce_end[31:0]); end
        tick();
        core_hashing = 4'hF;
        tick();
        tick();
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL small_early_done: got %b expected 0", done); end
        core_hashing = 4'hE;
        tick();
        vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL small_done: got %b expected 1", done); end
        tick();
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL small_idle: done %b busy %b expected 0 0", done, busy); end
        core_hashing = 4'h0;
    endtask

    task automatic test_reject();
        work_valid = 1'b1; work_nonce_start = 32'd50; work_nonce_end = 32'd40;
        tick();
        work_valid = 1'b0;
        vec_cnt++; if (done !== 1'b1 || busy !== 1'b0 || core_new_work !== 4'h0)
            begin err_cnt++; $display("FAIL reject: done %b busy %b new_work %h expected 1 0 0", done, busy, core_new_work); end
        tick();
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reject_pulse: got %b expected 0", done); end
    endtask

    task automatic test_fifo_full();
        result_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            core_result_data = '0;
            core_result_data[32*(k%4) +: 32] = 32'h100 + 32'(k);
            core_new_result = 4'b0001 << (k % 4);
            tick();
            core_new_result = 4'b0000;
            tick();
        end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL full_no_overflow: got %b expected 0", overflow); end
        vec_cnt++; if (result_valid !== 1'b1 || result_nonce !== 32'h100)
            begin err_cnt++; $display("FAIL full_head: got %b/%h expected 1/00000100", result_valid, result_nonce); end
        core_result_data = '0;
        core_result_data[31:0] = 32'hDEAD;
        core_new_result = 4'b0001;
        tick();
        core_new_result = 4'b0000;
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        result_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            vec_cnt++; if (result_valid !== 1'b1 || result_nonce !== 32'h100 + 32'(k))
                begin err_cnt++; $display("FAIL full_drain_%0d: got %b/%h expected 1/%h", k, result_valid, result_nonce, 32'h100 + 32'(k)); end
            tick();
        end
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL full_empty: got %b expected 0", result_valid); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL full_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_abort();
        launch(32'd0, 32'd99);
        result_ready = 1'b0;
        core_result_data = '0;
        core_result_data[95:64] = 32'h55;
        core_new_result = 4'b0100;
        tick();
        core_new_result = 4'b0000;
        tick();
        vec_cnt++; if (result_valid !== 1'b1 || result_nonce !== 32'h55)
            begin err_cnt++; $display("FAIL abort_prefill: got %b/%h expected 1/00000055", result_valid, result_nonce); end
        work_valid = 1'b1; work_nonce_start = 32'd1000; work_nonce_end = 32'd1399;
        core_result_data[63:32] = 32'h77;
        core_new_result = 4'b0010;
        tick();
        work_valid = 1'b0;
        core_new_result = 4'b0000;
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_flush: got %b expected 0", result_valid); end
        vec_cnt++; if (core_new_work !== 4'hF || done !== 1'b0)
            begin err_cnt++; $display("FAIL abort_relaunch: new_work %h done %b expected f 0", core_new_work, done); end
        vec_cnt++; if (core_nonce_start !== {32'd1300, 32'd1200, 32'd1100, 32'd1000})
            begin err_cnt++; $display("FAIL abort_start: got %h expected %h", core_nonce_start, {32'd1300, 32'd1200, 32'd1100, 32'd1000}); end
        vec_cnt++; if (core_nonce_end !== {32'd1399, 32'd1299, 32'd1199, 32'd1099})
            begin err_cnt++; $display("FAIL abort_end: got %h expected %h", core_nonce_end, {32'd1399, 32'd1299, 32'd1199, 32'd1099}); end
        tick();
        vec_cnt++; if (result_valid !== 1'b0 || done !== 1'b0)
            begin err_cnt++; $display("FAIL abort_ignore: valid %b done %b expected 0 0", result_valid, done); end
        tick();
        vec_cnt++; if (result_valid !== 1'b0 || busy !== 1'b1)
            begin err_cnt++; $display("FAIL abort_run: valid %b busy %b expected 0 1", result_valid, busy); end
        core_hashing = 4'h0;
        tick();
        vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL abort_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        launch(32'd0, 32'd99);
        result_ready = 1'b0;
        core_result_data = '0;
        core_result_data[31:0] = 32'h99;
        core_new_result = 4'b0001;
        tick();
        core_new_result = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        vec_cnt++; if (busy !== 1'b0 || result_valid !== 1'b0)
            begin err_cnt++; $display("FAIL midreset_state: busy %b valid %b expected 0 0", busy, result_valid); end
        vec_cnt++; if (overflow !== 1'b0 || core_new_work !== 4'h0 || done !== 1'b0)
            begin err_cnt++; $display("FAIL midreset_outputs: overflow %b new_work %h done %b expected 0 0 0", overflow, core_new_work, done); end
        reset = 1'b0;
        core_hashing = 4'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_split();
        test_round_robin();
        test_small_range();
        test_reject();
        test_fifo_full();
        test_abort();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
